mem_dma_engine: RTL
===================

# mem_dma_engine

Block-transfer initiator for the data memory port. Given a start pulse, it walks a contiguous word range and either copies words from a source range to a destination range or fills a destination range with a constant. It drives the same address/write-data/write-enable/read-data interface the CPU uses, and only advances when the top-level arbiter grants the port. It sits beside the pipeline's memory stage; the arbiter muxes the port using `mem_req`/`mem_gnt`.

## Interface
- `ADDR_WIDTH`, 16: width of the address pointers and the length counter; matches the data memory address port.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  request pulse; accepted only in IDLE.
- `mode`  in  1  transfer mode: 0 = copy, 1 = fill; sampled with `start`.
- `src_addr`  in  16  first source word address (copy mode only); sampled with `start`.
- `dst_addr`  in  16  first destination word address; sampled with `start`.
- `fill_data`  in  16  constant written in fill mode; sampled with `start`.
- `length`  in  16  number of words to transfer; sampled with `start`.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle completion pulse.
- `words_done`  out  16  count of words written in the current or most recent transfer.
- `mem_req`  out  1  requests the data memory port.
- `mem_gnt`  in  1  port granted this cycle.
- `mem_access_addr`  out  16  address to data memory.
- `mem_write_data`  out  16  write data to data memory.
- `mem_write_en`  out  1  write strobe to data memory.
- `mem_read_data`  in  16  combinational read data for `mem_access_addr`, valid in the same cycle.

## Operation
- **States:** IDLE, RD, WR, DONE.
- **IDLE:**
  - `start` = 1 latches `mode`, `src_addr`, `dst_addr`, `fill_data` and `length`, and clears `words_done`.
  - Next state: `length` = 0 goes to DONE; copy mode goes to RD; fill mode loads `fill_data` into the data buffer and goes to WR.
- **RD (copy only):**
  - `mem_req` = 1, `mem_access_addr` = source pointer.
  - When `mem_gnt` = 1: capture `mem_read_data` into the buffer and go to WR. Otherwise hold.
- **WR:**
  - `mem_req` = 1, `mem_access_addr` = destination pointer, `mem_write_data` = buffer.
  - `mem_write_en` = `mem_gnt` (combinational). No write is issued without a grant.
  - On a granted write: increment both pointers, decrement the remaining count, increment `words_done`.
  - Next state after a granted write: remaining = 1 goes to DONE; otherwise copy mode goes to RD and fill mode stays in WR.
- **DONE:** `done` = 1 for exactly one cycle, then go to IDLE.
- **Arithmetic:** pointers and counters are 16-bit and wrap modulo 2^16 (0xFFFF + 1 = 0x0000). The memory itself uses only the low address bits.
- **Overlapping ranges:** the copy is always ascending with no overlap check. With `dst_addr` > `src_addr` and the ranges overlapping, the result is a replicated pattern; this is the defined behaviour.
- **Ignored inputs:** `start` while `busy` is ignored. Input changes after acceptance have no effect.
- **Idle outputs:** when not in RD or WR, `mem_req`, `mem_write_en`, `mem_access_addr` and `mem_write_data` are all 0.

## Timing
- **Reset values:**
  - state IDLE.
  - `busy`, `done`, `mem_req`, `mem_write_en` = 0.
  - `words_done`, `mem_access_addr`, `mem_write_data` = 0.
- **Reset mid-transfer:** takes effect at the next edge. No further writes are issued, `done` is not pulsed, and the partial memory contents are left as written.
- **Copy of N words with `mem_gnt` held at 1:** `start` is sampled at edge 0. RD occupies cycle 2k+1 and WR cycle 2k+2, for k = 0..N-1. `done` is high in cycle 2N+1 and `busy` in cycles 1..2N+1.
- **Fill of N words with `mem_gnt` held at 1:** WR occupies cycles 1..N, and `done` is high in cycle N+1.
- **`length` = 0:** `done` is high in cycle 1 with no memory access.
- **Grant low:** each cycle with `mem_gnt` = 0 in RD or WR adds exactly one cycle and leaves outputs stable.
- **Start during DONE:** a `start` in the DONE cycle is ignored. The earliest new start is accepted on the cycle `busy` is low.

## Structure
- The state encoding (2-bit) and the mode constants (`DMA_MODE_COPY` = 0, `DMA_MODE_FILL` = 1) go in the shared defines header `mips_16_defs.v`.
- Single module with no sub-modules: state register, two pointers, remaining counter, `words_done` counter and one 16-bit data buffer.

## Test plan
- **Basic copy:** preload mem[0x10..0x13] = 0xA001..0xA004; copy src 0x10 → dst 0x40, length 4, `mem_gnt` = 1 → mem[0x40..0x43] = 0xA001..0xA004, `done` at cycle 9, `words_done` = 4.
- **Fill:** fill 0x20, length 3, `fill_data` 0xBEEF → mem[0x20..0x22] = 0xBEEF with three consecutive write strobes; `done` at cycle 4.
- **Grant stalls:** copy length 2 with `mem_gnt` toggling 1,0,1,0… → same final data, total latency grows by the number of ungranted RD/WR cycles, and `mem_write_en` is never high while `mem_gnt` = 0.
- **Zero length and ignored start:** `length` 0 → `done` in cycle 1 with no `mem_req`. A second `start` while `busy` leaves the running transfer's addresses unchanged.
- **Wrap-around:** fill `dst_addr` 0xFFFE, length 3 → writes to 0xFFFE, 0xFFFF, 0x0000.
- **Reset mid-transfer:** assert `rst` after 2 of 8 fill words → outputs go to 0 at the next edge, only 2 words are written, and no `done` pulse occurs.

Source files
------------

// File: rtl/mem_dma_engine_pkg.sv
// Shared types for the block-transfer DMA initiator: FSM state encoding and
// transfer-mode constants.
package mem_dma_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } dma_state_e;

  localparam logic DMA_MODE_COPY = 1'b0;
  localparam logic DMA_MODE_FILL = 1'b1;

endpackage

// File: rtl/mem_dma_engine.sv
// Block copy/fill initiator on the data memory port; advances one read or
// write per granted cycle, ascending through the address range.
module mem_dma_engine
  import mem_dma_engine_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [DATA_W-1:0]     fill_data,
  input  logic [ADDR_WIDTH-1:0] length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] words_done,
  output logic                  mem_req,
  input  logic                  mem_gnt,
  output logic [ADDR_WIDTH-1:0] mem_access_addr,
  output logic [DATA_W-1:0]     mem_write_data,
  output logic                  mem_write_en,
  input  logic [DATA_W-1:0]     mem_read_data
);

  dma_state_e            state_q, state_d;
  logic                  mode_q;
  logic [ADDR_WIDTH-1:0] src_q, dst_q, rem_q, words_done_q;
  logic [DATA_W-1:0]     buf_q;

  logic accept, rd_fire, wr_fire, last_word;

  assign accept    = (state_q == ST_IDLE) && start;
  assign rd_fire   = (state_q == ST_RD) && mem_gnt;
  assign wr_fire   = (state_q == ST_WR) && mem_gnt;
  assign last_word = (rem_q == ADDR_WIDTH'(1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (length == '0)                state_d = ST_DONE;
          else if (mode == DMA_MODE_FILL)  state_d = ST_WR;
          else                             state_d = ST_RD;
        end
      end
      ST_RD:   if (mem_gnt) state_d = ST_WR;
      ST_WR: begin
        if (mem_gnt) begin
          if (last_word)                    state_d = ST_DONE;
          else if (mode_q == DMA_MODE_COPY) state_d = ST_RD;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state: FSM and the word counter, both cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      words_done_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept)       words_done_q <= '0;
      else if (wr_fire) words_done_q <= words_done_q + ADDR_WIDTH'(1);
    end
  end

  // Datapath: pointers, remaining count and the single-word buffer
  always_ff @(posedge clk) begin
    if (accept) begin
      mode_q <= mode;
      src_q  <= src_addr;
      dst_q  <= dst_addr;
      rem_q  <= length;
      if (mode == DMA_MODE_FILL) buf_q <= fill_data;
    end else begin
      if (rd_fire) buf_q <= mem_read_data;
      if (wr_fire) begin
        src_q <= src_q + ADDR_WIDTH'(1);
        dst_q <= dst_q + ADDR_WIDTH'(1);
        rem_q <= rem_q - ADDR_WIDTH'(1);
      end
    end
  end

  always_comb begin
    busy            = (state_q != ST_IDLE);
    done            = (state_q == ST_DONE);
    words_done      = words_done_q;
    mem_req         = 1'b0;
    mem_access_addr = '0;
    mem_write_data  = '0;
    mem_write_en    = 1'b0;
    if (state_q == ST_RD) begin
      mem_req         = 1'b1;
      mem_access_addr = src_q;
    end else if (state_q == ST_WR) begin
      mem_req         = 1'b1;
      mem_access_addr = dst_q;
      mem_write_data  = buf_q;
      mem_write_en    = mem_gnt;
    end
  end

endmodule
